// File: rtl/car_sensor_encoder_if.sv
// rtl/car_sensor_encoder_if.sv - enter/exit pulse bundle between the sensor encoder and its consumer
interface car_sensor_encoder_if;
    logic Car_Enter;
    logic Car_Exit;
    logic Busy;
    logic Fault;

    modport master (output Car_Enter, output Car_Exit, output Busy, output Fault);
    modport slave  (input  Car_Enter, input  Car_Exit, input  Busy, input  Fault);
endinterface

// File: rtl/car_sensor_encoder.sv
// rtl/car_sensor_encoder.sv - beam-break sensor pair to Car_Enter/Car_Exit pulse encoder
// Optional crossing timeout and sticky Fault flag enabled by macro SENSOR_FAULT_EN.
module car_sensor_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Sensor_A,
    input  logic                        Sensor_B,
    car_sensor_encoder_if.master        pulse_if
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("car_sensor_encoder: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENT1       = 3'd1,
        ENT2       = 3'd2,
        ENT3       = 3'd3,
        EXT1       = 3'd4,
        EXT2       = 3'd5,
        EXT3       = 3'd6,
        WAIT_CLEAR = 3'd7
    } state_t;

    // The toggle fires on the sample that would bring the run length up to DEBOUNCE_CYCLES.
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0][7:0]  cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             enter_q, enter_d;
    logic             exit_q, exit_d;
    logic             a, b;
    logic             timeout;

    assign a = deb_q[0];
    assign b = deb_q[1];

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a && !b)       state_d = ENT1;
                else if (!a && b)  state_d = EXT1;
                else if (a && b)   state_d = WAIT_CLEAR;
            end
            ENT1: begin
                if (a && b)        state_d = ENT2;
                else if (!a && !b) state_d = IDLE;
            end
            ENT2: begin
                if (!a && b)       state_d = ENT3;
                else if (a && !b)  state_d = ENT1;
                else if (!a && !b) state_d = WAIT_CLEAR;
            end
            ENT3: begin
                if (!a && !b) begin
                    state_d = IDLE;
                    enter_d = 1'b1;
                end else if (a) begin
                    state_d = ENT2;
                end
            end
            EXT1: begin
                if (a && b)        state_d = EXT2;
                else if (!a && !b) state_d = IDLE;
            end
            EXT2: begin
                if (a && !b)       state_d = EXT3;
                else if (!a && b)  state_d = EXT1;
                else if (!a && !b) state_d = WAIT_CLEAR;
            end
            EXT3: begin
                if (!a && !b) begin
                    state_d = IDLE;
                    exit_d  = 1'b1;
                end else if (b) begin
                    state_d = EXT2;
                end
            end
            WAIT_CLEAR: begin
                if (!a && !b)      state_d = IDLE;
            end
            default:               state_d = IDLE;
        endcase
        // A stalled crossing is abandoned without a pulse; WAIT_CLEAR just keeps waiting.
        if (timeout && state_q != WAIT_CLEAR) begin
            state_d = WAIT_CLEAR;
            enter_d = 1'b0;
            exit_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            sync1_q <= {Sensor_B, Sensor_A};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

`ifdef SENSOR_FAULT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] dwell_q, dwell_d;
    logic        fault_q, fault_d;

    assign timeout = (state_q != IDLE) && (dwell_q == TMO_LAST);

    always_comb begin
        dwell_d = dwell_q + 16'd1;
        if (state_d != state_q || state_q == IDLE) begin
            dwell_d = '0;
        end
        fault_d = fault_q | timeout;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            dwell_q <= '0;
            fault_q <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            fault_q <= fault_d;
        end
    end

    assign pulse_if.Fault = fault_q;
`else
    assign timeout        = 1'b0;
    assign pulse_if.Fault = 1'b0;
`endif

    assign pulse_if.Car_Enter = enter_q;
    assign pulse_if.Car_Exit  = exit_q;
    assign pulse_if.Busy      = (state_q != IDLE);

endmodule

// File: doc/car_sensor_encoder.md
# car_sensor_encoder

Front-end that converts two raw entrance beam-break sensors into the single-cycle `Car_Enter` / `Car_Exit` pulses consumed by `Smart_Parking_System`. It is the transmitting end of the enter/exit pulse interface.
- Sensor A sits on the street side and sensor B on the lot side.
- A car breaking A then B then clearing is an entry; the reverse order is an exit.
- The block synchronises and debounces both sensors, tracks the crossing order with a state machine, and emits exactly one pulse per completed crossing.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced level changes (legal range 1–255).
- `TIMEOUT_CYCLES`, default 1000: maximum cycles any crossing may stay incomplete before it is declared a fault (legal range 2–65535). Used only with `SENSOR_FAULT_EN`.

Ports:
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-low reset.
- `Sensor_A` in 1: raw street-side beam, asynchronous; 1 = beam broken.
- `Sensor_B` in 1: raw lot-side beam, asynchronous; 1 = beam broken.
- `Car_Enter` out 1: one-cycle pulse per completed entry.
- `Car_Exit` out 1: one-cycle pulse per completed exit.
- `Busy` out 1: high whenever the FSM is not in IDLE.
- `Fault` out 1: sticky timeout flag.

## Operation
- Each sensor passes through a 2-flop synchroniser, then its own debouncer.
- Debouncer: an 8-bit counter resets whenever the synchronised input equals the current debounced level. When the counter reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears. Glitches shorter than `DEBOUNCE_CYCLES` cycles are absorbed.
- In the transitions below, `a` and `b` are the debounced levels.
- FSM states: IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, WAIT_CLEAR.
- IDLE:
  - a=1, b=0 → ENT1
  - a=0, b=1 → EXT1
  - a=1, b=1 (both rise in the same cycle, ambiguous) → WAIT_CLEAR
- ENT1: a=1, b=1 → ENT2; a=0, b=0 → IDLE (car backed out, no pulse).
- ENT2: a=0, b=1 → ENT3; a=1, b=0 → ENT1; a=0, b=0 → WAIT_CLEAR.
- ENT3: a=0, b=0 → IDLE with `Car_Enter` pulse; a=1 → ENT2.
- EXT1–EXT3: mirror of ENT1–ENT3 with a and b swapped; completion emits a `Car_Exit` pulse.
- WAIT_CLEAR: stay until a=0 and b=0, then go to IDLE. No pulse is ever emitted from this state.
- `Car_Enter` and `Car_Exit` are registered outputs, high for exactly one cycle and never high together.
- Reset values: all outputs 0, FSM in IDLE, debounced levels 0, all counters 0.
- Reset asserted mid-crossing aborts the crossing silently; no pulse is emitted.

## Timing
- A raw edge that stays stable is reflected in the debounced level after 2 + `DEBOUNCE_CYCLES` cycles.
- The FSM transitions on the cycle after the debounced change. A completing transition registers the pulse on that same edge.
- Latency from the final raw sensor release to the pulse is `DEBOUNCE_CYCLES` + 3 cycles (7 at the default).
- Consecutive crossings need no gap beyond returning to IDLE. Back-to-back cars produce pulses at least `DEBOUNCE_CYCLES` + 1 cycles apart.
- `Busy` is combinational from the state register (state != IDLE).

## Configuration
- Macro `SENSOR_FAULT_EN`.
- Defined:
  - A 16-bit dwell counter clears on every state change and on entry to IDLE, and increments in every non-IDLE state.
  - When it reaches `TIMEOUT_CYCLES`, `Fault` sets and the FSM goes to WAIT_CLEAR. The aborted crossing produces no pulse.
  - `Fault` stays high until `RST`.
  - The dwell counter also runs in WAIT_CLEAR, but reaching the limit there only sets `Fault`; the FSM does not change state.
- Undefined: no dwell counter, `Fault` tied to 0, and the FSM never times out.

## Test plan
- **Entry.** Reset, then drive A=1 for 20 cycles, A=B=1 for 20, B only for 20, then both 0. Required: exactly one `Car_Enter` pulse, 7 cycles after B falls; `Car_Exit` stays 0; `Busy` back to 0.
- **Exit.** Mirror sequence B, AB, A, none. Required: exactly one `Car_Exit` pulse and no `Car_Enter`.
- **Glitch rejection.** 3-cycle pulses on A and on B, at least 10 cycles apart. Required: debounced levels stay 0, FSM stays IDLE, no pulses.
- **Back-out.** A=1, A=B=1, A only, then none. Required: no pulses and FSM returns to IDLE.
- **Reset mid-crossing.** Reach ENT3, pull `RST` low for 1 cycle, release with sensors clear. Required: no pulse, all outputs 0 on the cycle after the reset edge.
- **Timeout (`SENSOR_FAULT_EN`, `TIMEOUT_CYCLES`=50).** Hold A=1 for 200 cycles. Required: `Fault` rises 50 cycles after entering ENT1 and stays high after A clears, and no pulse is emitted. Without the macro: `Fault` stays 0.
